// File: rtl/sram_like_data_ram.sv
// On-chip data memory answering the data cache's SRAM-like bus (req / addr_ok / data_ok).
// Byte-masked writes and full-word reads, in-order responses after a fixed latency.
module sram_like_data_ram #(
  parameter int DEPTH_LOG2      = 10,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        addr_ok,
  output logic        data_ok
);

  localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [31:0]           mem [2**DEPTH_LOG2];
  logic [LATENCY-1:0]    pipe_valid;
  logic [31:0]           pipe_data [LATENCY];
  logic [CNT_W-1:0]      cnt;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [3:0]            wmask;
  logic                  accept;
  logic                  unused_addr_bits;

  // Upper address bits alias onto the same word.
  assign word_idx         = addr[DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^addr[31:DEPTH_LOG2+2];

  // A response leaving this cycle frees a slot, so a full responder can still accept.
  assign addr_ok = req & ~rst & ((cnt < CNT_MAX) | data_ok);
  assign accept  = req & addr_ok;
  assign data_ok = pipe_valid[LATENCY-1];
  assign rdata   = pipe_data[LATENCY-1];

  always_comb begin
    wmask = 4'b0000;
    case (size)
      2'd0:    wmask[addr[1:0]] = 1'b1;
      2'd1:    wmask = addr[1] ? 4'b1100 : 4'b0011;
      default: wmask = 4'b1111;
    endcase
  end

  // Memory contents survive reset; only accepted writes touch them.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Data only advances behind a valid bit, so the last stage holds the previous response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid <= '0;
      for (int s = 0; s < LATENCY; s++) pipe_data[s] <= 32'h0;
    end else begin
      pipe_valid[0] <= accept;
      if (accept) pipe_data[0] <= wr ? 32'h0 : mem[word_idx];
      for (int s = 1; s < LATENCY; s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
        if (pipe_valid[s-1]) pipe_data[s] <= pipe_data[s-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept && !data_ok) begin
      cnt <= cnt + CNT_W'(1);
    end else if (!accept && data_ok) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule
